rf_sequencer: RTL and testbench

- Drives the two-entry register file through its `main_enable` / `instr` / `data_in` interface. It is the writer and issuer for that interface.
- Executes a small program held in internal instruction memory. The memory is loaded through a write port.
- Keeps a shadow copy of both registers and computes ADD results itself, so the register file only ever receives finished 4-bit write data.
- Sits between the test/load logic and the register file; its `rf_*` ports wire directly to the register file's ports of the same meaning.

---
 rtl/rf_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_rf_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_sequencer.sv
// rf_sequencer: runs a small stored program against the two-entry register file,
// computing ADD results locally. Optional build macro: RF_SEQ_CHECK_EN (readback compare, mismatch output).
module rf_sequencer #(
    parameter int unsigned DATASIZE   = 8,
    parameter int unsigned PROG_DEPTH = 16,
    parameter int unsigned ADDR_W     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                prog_we,
    input  logic [ADDR_W-1:0]   prog_addr,
    input  logic [7:0]          prog_data,
    output logic                rf_main_enable,
    output logic [7:0]          rf_instr,
    output logic [7:0]          rf_data_in,
    input  logic [DATASIZE-1:0] rf_out_A,
    input  logic [DATASIZE-1:0] rf_out_B,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   pc
`ifdef RF_SEQ_CHECK_EN
    ,
    output logic                mismatch
`endif
);

    localparam logic [2:0]        OP_ADD   = 3'b000;
    localparam logic [2:0]        OP_SAVE  = 3'b110;
    localparam logic [2:0]        OP_HALT  = 3'b111;
    localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(PROG_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_GAP,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic [7:0]        instr_q, instr_d;
    logic [7:0]        data_q, data_d;
    logic [1:0][3:0]   shadow_q, shadow_d;
    logic [7:0]        mem_q [PROG_DEPTH];

    logic              idle_or_done;
    logic              launch;
    logic [2:0]        opcode;
    logic [3:0]        sum;

    assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
    assign launch       = idle_or_done && start;
    assign opcode       = ir_q[7:5];
    assign sum          = shadow_q[ir_q[4]] + shadow_q[ir_q[3]];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        instr_d  = instr_q;
        data_d   = data_q;
        shadow_d = shadow_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: begin
                ir_d    = mem_q[pc_q];
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_HALT: state_d = S_DONE;
                    OP_ADD: begin
                        instr_d            = ir_q;
                        data_d             = {4'b0000, sum};
                        shadow_d[ir_q[2]]  = sum;
                        state_d            = S_ISSUE;
                    end
                    OP_SAVE: begin
                        instr_d            = ir_q;
                        data_d             = {3'b000, ir_q[4:0]};
                        shadow_d[ir_q[4]]  = ir_q[3:0];
                        state_d            = S_ISSUE;
                    end
                    // Remaining opcodes would clear the register file, so they are skipped.
                    default: state_d = S_GAP;
                endcase
            end
            S_ISSUE: state_d = S_GAP;
            S_GAP: begin
                if (pc_q == LAST_PC) begin
                    state_d = S_DONE;
                end else begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            instr_q  <= '0;
            data_q   <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            instr_q  <= instr_d;
            data_q   <= data_d;
            shadow_q <= shadow_d;
        end
    end

    // Program memory survives reset; writes are accepted only while not executing.
    always_ff @(posedge clk) begin
        if (prog_we && idle_or_done) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    assign rf_main_enable = (state_q == S_ISSUE);
    assign rf_instr       = instr_q;
    assign rf_data_in     = data_q;
    assign busy           = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                            (state_q == S_ISSUE) || (state_q == S_GAP);
    assign done           = (state_q == S_DONE);
    assign pc             = pc_q;

`ifdef RF_SEQ_CHECK_EN
    logic       was_add_q, was_add_d;
    logic [3:0] exp_a_q, exp_a_d;
    logic [3:0] exp_b_q, exp_b_d;
    logic       mismatch_q, mismatch_d;

    // Expected readback is captured from the pre-update shadows while decoding.
    always_comb begin
        was_add_d  = was_add_q;
        exp_a_d    = exp_a_q;
        exp_b_d    = exp_b_q;
        mismatch_d = mismatch_q;
        if (launch) begin
            mismatch_d = 1'b0;
        end
        if (state_q == S_DECODE) begin
            was_add_d = (opcode == OP_ADD);
            if (ir_q[4] == ir_q[3]) begin
                exp_a_d = shadow_q[0];
                exp_b_d = shadow_q[1];
            end else begin
                exp_a_d = shadow_q[ir_q[4]];
                exp_b_d = shadow_q[ir_q[3]];
            end
        end
        if ((state_q == S_GAP) && was_add_q) begin
            if ((rf_out_A != DATASIZE'(exp_a_q)) || (rf_out_B != DATASIZE'(exp_b_q))) begin
                mismatch_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            was_add_q  <= 1'b0;
            exp_a_q    <= '0;
            exp_b_q    <= '0;
            mismatch_q <= 1'b0;
        end else begin
            was_add_q  <= was_add_d;
            exp_a_q    <= exp_a_d;
            exp_b_q    <= exp_b_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`else
    logic unused_rf_out;
    assign unused_rf_out = ^{rf_out_A, rf_out_B, launch};
`endif

endmodule

// File: tb/tb_rf_sequencer.sv
// Directed self-checking bench for rf_sequencer; exercises the RF_SEQ_CHECK_EN path when that macro is defined.
module tb_rf_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic       rf_main_enable;
    logic [7:0] rf_instr;
    logic [7:0] rf_data_in;
    logic [7:0] rf_out_A;
    logic [7:0] rf_out_B;
    logic       busy;
    logic       done;
    logic [3:0] pc;
`ifdef RF_SEQ_CHECK_EN
    logic       mismatch;
`endif

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [7:0]  p_instr [$];
    logic [7:0]  p_data  [$];
    int unsigned p_idx   [$];
    int unsigned done_idx;
    bit          double_pulse;
    bit          busy_drop;
    int unsigned en_cnt;
    int unsigned en_at;

    rf_sequencer #(
        .DATASIZE   (8),
        .PROG_DEPTH (16),
        .ADDR_W     (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .prog_we        (prog_we),
        .prog_addr      (prog_addr),
        .prog_data      (prog_data),
        .rf_main_enable (rf_main_enable),
        .rf_instr       (rf_instr),
        .rf_data_in     (rf_data_in),
        .rf_out_A       (rf_out_A),
        .rf_out_B       (rf_out_B),
        .busy           (busy),
        .done           (done),
        .pc             (pc)
`ifdef RF_SEQ_CHECK_EN
        ,
        .mismatch       (mismatch)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int unsigned addr, input logic [7:0] data);
        prog_we   = 1'b1;
        prog_addr = addr[3:0];
        prog_data = data;
        tick();
        prog_we   = 1'b0;
    endtask

    // Sample index 1 is the first sample after the edge that takes start.
    task automatic run(input int unsigned max_cyc, input bit poke);
        bit prev_en;
        p_instr.delete();
        p_data.delete();
        p_idx.delete();
        done_idx     = 0;
        double_pulse = 1'b0;
        busy_drop    = 1'b0;
        prev_en      = 1'b0;
        start        = 1'b1;
        tick();
        for (int unsigned i = 1; i <= max_cyc; i++) begin
            if (i > 1) tick();
            if (rf_main_enable) begin
                p_instr.push_back(rf_instr);
                p_data.push_back(rf_data_in);
                p_idx.push_back(i);
                if (prev_en) double_pulse = 1'b1;
            end
            prev_en = rf_main_enable;
            if (poke && i == 2) begin
                start     = 1'b1;
                prog_we   = 1'b1;
                prog_addr = 4'd5;
                prog_data = 8'hE0;
            end else begin
                start   = 1'b0;
                prog_we = 1'b0;
            end
            if (done) begin
                done_idx = i;
                break;
            end
            if (!busy) busy_drop = 1'b1;
        end
        start   = 1'b0;
        prog_we = 1'b0;
        chk("run_reached_done", done_idx != 0, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        rf_out_A = '0; rf_out_B = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_instr", rf_instr, 8'h00);
        chk("reset_data", rf_data_in, 8'h00);
`ifdef RF_SEQ_CHECK_EN
        chk("reset_mismatch", mismatch, 0);
`endif
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_en_busy_done_pc", {rf_main_enable, busy, done, pc}, 7'd0);
        end

        // start and prog_we together in IDLE: written word must be fetched
        load(1, 8'hE0);
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = 8'hC7;
        run(20, 0);
        chk("simul_we_pulses", p_idx.size(), 1);
        if (p_idx.size() == 1) chk("simul_we_data", p_data[0], 8'h07);

        // SAVE r0=3, SAVE r1=5, ADD r1+r1->r1, HALT
        load(0, 8'hC3); load(1, 8'hD5); load(2, 8'h1C); load(3, 8'hE0);
        run(40, 0);
        chk("t1_pulses", p_idx.size(), 3);
        if (p_idx.size() == 3) begin
            chk("t1_idx0", p_idx[0], 3);
            chk("t1_idx1", p_idx[1], 7);
            chk("t1_idx2", p_idx[2], 11);
            chk("t1_data0", p_data[0], 8'h03);
            chk("t1_data1", p_data[1], 8'h15);
            chk("t1_data2", p_data[2], 8'h0A);
            chk("t1_instr2", p_instr[2], 8'h1C);
        end
        chk("t1_done_idx", done_idx, 15);
        chk("t1_pc", pc, 4'd3);
        chk("t1_single_pulses", double_pulse, 0);
        chk("t1_busy_held", busy_drop, 0);
        chk("t1_hold_data", rf_data_in, 8'h0A);
        chk("t1_hold_instr", rf_instr, 8'h1C);
        chk("t1_en_low_done", {rf_main_enable, busy, done}, 3'b001);

        // SAVE r0=9, SAVE r1=9, ADD r0+r1->r0 wraps mod 16
        load(0, 8'hC9); load(1, 8'hD9); load(2, 8'h08); load(3, 8'hE0);
        rf_out_A = 8'h09; rf_out_B = 8'h09;
        run(40, 0);
        chk("t2_pulses", p_idx.size(), 3);
        if (p_idx.size() == 3) begin
            chk("t2_data1", p_data[1], 8'h19);
            chk("t2_add_data", p_data[2], 8'h02);
            chk("t2_add_instr", p_instr[2], 8'h08);
        end
`ifdef RF_SEQ_CHECK_EN
        chk("t2_no_mismatch", mismatch, 0);
        rf_out_B = 8'h03;
        run(40, 0);
        chk("t2_mismatch_set", mismatch, 1);
        tick();
        chk("t2_mismatch_sticky", mismatch, 1);
`endif

        // NOP between SAVEs: no pulse, shadows intact for the following ADD
        load(0, 8'hC2); load(1, 8'h20); load(2, 8'hD7); load(3, 8'h0C); load(4, 8'hE0);
        rf_out_A = 8'h02; rf_out_B = 8'h07;
        run(40, 0);
        chk("t3_pulses", p_idx.size(), 3);
        if (p_idx.size() == 3) begin
            chk("t3_idx1_after_nop", p_idx[1], 10);
            chk("t3_data1", p_data[1], 8'h17);
            chk("t3_add_data", p_data[2], 8'h09);
        end
        chk("t3_done_idx", done_idx, 18);
`ifdef RF_SEQ_CHECK_EN
        chk("t3_mismatch_cleared", mismatch, 0);
`endif

        // Full memory of SAVEs, no HALT
        for (int unsigned a = 0; a < 16; a++) load(a, 8'hC0 | 8'(a));
        run(100, 0);
        chk("t4_pulses", p_idx.size(), 16);
        if (p_idx.size() == 16) chk("t4_last_data", p_data[15], 8'h0F);
        chk("t4_done_idx", done_idx, 65);
        chk("t4_pc_last", pc, 4'd15);
        // rerun; a start and a prog_we issued while busy must both be ignored
        run(100, 1);
        chk("t4r_pulses", p_idx.size(), 16);
        if (p_idx.size() == 16) begin
            chk("t4r_idx0", p_idx[0], 3);
            chk("t4r_data0", p_data[0], 8'h00);
            chk("t4r_data5", p_data[5], 8'h05);
        end
        chk("t4r_done_idx", done_idx, 65);

        // Reset during the ISSUE of the second instruction
        load(0, 8'hC3); load(1, 8'hD5); load(2, 8'h08); load(3, 8'hE0);
        start = 1'b1;
        tick();
        start  = 1'b0;
        en_cnt = 0;
        en_at  = 0;
        for (int unsigned i = 2; i <= 20; i++) begin
            tick();
            if (rf_main_enable) en_cnt++;
            if (en_cnt == 2) begin
                en_at = i;
                break;
            end
        end
        chk("rst_issue2_cycle", en_at, 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_abort_state", {rf_main_enable, busy, done, pc}, 7'd0);
        chk("rst_abort_instr", rf_instr, 8'h00);
        tick();
        chk("rst_no_late_pulse", rf_main_enable, 0);
        // Cleared shadows: r0 + r1 must now be 0
        load(0, 8'h08); load(1, 8'hE0);
        run(20, 0);
        chk("rst_pulses", p_idx.size(), 1);
        if (p_idx.size() == 1) chk("rst_shadow_cleared", p_data[0], 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
